// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one full-adder cell plus a carry flip-flop, LSB first.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only in IDLE
//   a, b   - WIDTH-bit operands, captured on the accepted start cycle
//   cin    - carry-in, captured on the accepted start cycle
//   busy   - high while the SHIFT phase runs (WIDTH cycles)
//   done   - one-cycle pulse, sum/cout valid from this cycle on
//   sum    - a+b+cin modulo 2^WIDTH, held until the next DONE or reset
//   cout   - carry out of bit WIDTH-1, held like sum
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_c;
    logic             w_last;

    assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c    = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
    assign w_last = r_cnt == CW'(WIDTH - 1);
    assign sum    = r_sum;
    assign cout   = r_cout;

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            S_IDLE:  w_next = start ? S_SHIFT : S_IDLE;
            S_SHIFT: begin
                busy   = 1'b1;
                w_next = w_last ? S_DONE : S_SHIFT;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // r_res holds only the WIDTH-1 bits produced before the last edge; the
    // final bit goes straight into r_sum so the published result updates
    // exactly on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_c     <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_a   <= a;
                r_b   <= b;
                r_c   <= cin;
                r_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_c   <= w_c;
                r_res <= (WIDTH-1)'({w_s, r_res} >> 1);
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_sum  <= {w_s, r_res};
                    r_cout <= w_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8 and WIDTH=32.
module tb_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s8 = 1'b0, c8 = 1'b0, busy8, done8, cout8;
    logic [7:0]  a8 = '0, b8 = '0, sum8;
    logic        s32 = 1'b0, c32 = 1'b0, busy32, done32, cout32;
    logic [31:0] a32 = '0, b32 = '0, sum32;

    int          n_cmp = 0, n_err = 0;
    int          m8 = 0, m32 = 0;
    logic [32:0] q8[$], q32[$];
    logic [32:0] held8 = '0, held32 = '0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .cin(c8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(s32), .a(a32), .b(b32), .cin(c32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
    );

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model phase per DUT: 0 idle, 1..W shifting, W+1 done.
    task automatic tick();
        logic [32:0] e;
        if (m8 == 0) begin
            if (s8 && rst_n) begin
                q8.push_back(33'(a8) + 33'(b8) + 33'(c8));
                m8 = 1;
            end
        end else m8 = (m8 == 9) ? 0 : m8 + 1;
        if (m32 == 0) begin
            if (s32 && rst_n) begin
                q32.push_back(33'(a32) + 33'(b32) + 33'(c32));
                m32 = 1;
            end
        end else m32 = (m32 == 33) ? 0 : m32 + 1;
        @(posedge clk);
        #1;
        chk("busy8", busy8, m8 >= 1 && m8 <= 8);
        chk("done8", done8, m8 == 9);
        if (m8 == 9) begin
            e = q8.pop_front();
            chk("res8", {24'b0, cout8, sum8}, e);
            held8 = e;
        end else chk("hold8", {24'b0, cout8, sum8}, held8);
        chk("busy32", busy32, m32 >= 1 && m32 <= 32);
        chk("done32", done32, m32 == 33);
        if (m32 == 33) begin
            e = q32.pop_front();
            chk("res32", {cout32, sum32}, e);
            held32 = e;
        end else chk("hold32", {cout32, sum32}, held32);
    endtask

    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c);
        a8 = a; b8 = b; c8 = c; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        repeat (9) tick();
    endtask

    task automatic add32(input logic [31:0] a, input logic [31:0] b, input logic c);
        a32 = a; b32 = b; c32 = c; s32 = 1'b1;
        tick();
        s32 = 1'b0;
        repeat (33) tick();
    endtask

    initial begin
        int k, bc, last;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        a8 = 8'h3C; b8 = 8'h0F; c8 = 1'b0; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        k = 0;
        bc = int'(busy8);
        while (!done8 && k < 40) begin
            tick();
            k++;
            bc += int'(busy8);
        end
        chk("lat8", 33'(k), 33'd8);
        chk("busycnt8", 33'(bc), 33'd8);
        chk("sum_3c_0f", {24'b0, cout8, sum8}, 33'h04B);
        tick();

        add8(8'hFF, 8'h01, 1'b0);
        chk("ff_01", {24'b0, cout8, sum8}, 33'h100);
        add8(8'hFF, 8'hFF, 1'b1);
        chk("ff_ff_1", {24'b0, cout8, sum8}, 33'h1FF);
        add8(8'h05, 8'hF8, 1'b1);
        chk("sub_5_7", {24'b0, cout8, sum8}, 33'h0FE);
        add8(8'h07, 8'hFA, 1'b1);
        chk("sub_7_5", {24'b0, cout8, sum8}, 33'h102);
        add32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        chk("ripple32", {cout32, sum32}, 33'h1_0000_0000);

        s8 = 1'b1;
        last = -1;
        for (int i = 0; i < 45; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            tick();
            if (done8) begin
                if (last >= 0) chk("period8", 33'(i - last), 33'd10);
                last = i;
            end
        end
        s8 = 1'b0;
        repeat (10) tick();

        a8 = 8'h3C; b8 = 8'h0F; c8 = 1'b0; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_res8", {24'b0, cout8, sum8}, 0);
        chk("rst_res32", {cout32, sum32}, 0);
        q8.delete(); q32.delete();
        m8 = 0; m32 = 0;
        held8 = '0; held32 = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        add8(8'h3C, 8'h0F, 1'b0);
        chk("post_rst", {24'b0, cout8, sum8}, 33'h04B);

        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); s8 = 1'b1;
            a32 = $urandom; b32 = $urandom; c32 = 1'($urandom); s32 = 1'b1;
            tick();
            s8 = 1'b0; s32 = 1'b0;
            repeat (33) begin
                a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
                a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
                tick();
            end
        end
        chk("q8_empty", 33'(q8.size()), 0);
        chk("q32_empty", 33'(q32.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
